dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- MEM-stage load/store engine and the consumer of the EX→MEM payload: ALU address, forwarded rd_data2, funct3, MemRead/MemWrite.
- Turns each access into one transaction on a req/gnt + rvalid data bus.
- Handles byte-lane alignment, store replication, load sign/zero extension and misalignment detection.
- Holds `stall_o` high until the access retires, which freezes IF/ID/EX and the EX→MEM register.

Parameters:
- DATA_WIDTH, 32, data and address width. Only 32 is supported.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  EX→MEM register holds a valid instruction
- mem_read_i  in  1  MemRead from EX→MEM
- mem_write_i  in  1  MemWrite from EX→MEM
- funct3_i  in  3  instruction[14:12]
- addr_i  in  DATA_WIDTH  alu_result (byte address)
- store_data_i  in  DATA_WIDTH  rd_data2 after forwarding
- stall_o  out  1  freeze upstream pipeline
- done_o  out  1  one-cycle retire pulse
- load_data_o  out  DATA_WIDTH  extended load result; feeds WB and the FW_MEM_DATA forward path
- misaligned_o  out  1  access faulted (misaligned or illegal funct3); qualified by done_o
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  DATA_WIDTH  word address, {addr[31:2],2'b00}
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  DATA_WIDTH  lane-replicated store data
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  response valid (loads and stores)
- dbus_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Reset values (async, rst_n low): state IDLE; all outputs 0, including the registered address, be, wdata and load_data.
- Access is present when req_valid_i & (mem_read_i | mem_write_i). If both read and write are set, the access is a write.
- States and transitions:
  - IDLE: `stall_o` = access present (combinational). On access, capture addr, funct3, we, be, wdata.
    - Legal access → REQ.
    - Misaligned or illegal → DONE with fault flag set.
    - No access → stay IDLE, no bus activity.
  - REQ: dbus_req_o=1 with captured fields held stable; stall_o=1. On dbus_gnt_i → WAIT, else stay. dbus_rvalid_i is ignored in REQ.
  - WAIT: dbus_req_o=0, stall_o=1. On dbus_rvalid_i, register the extended load result into load_data_o (stores leave load_data_o unchanged) → DONE.
  - DONE: stall_o=0, done_o=1, misaligned_o=fault flag → IDLE unconditionally. req_valid_i is ignored in DONE, so the same instruction is never accepted twice.
- Minimum latency:
  - Accept in cycle T, request in T+1 (gnt same cycle), rvalid in T+2, done_o in T+3.
  - Faulted access: done_o in T+1.
- Byte enables from funct3[1:0]:
  - 00 (byte): 4'b0001 << addr[1:0]
  - 01 (half): 4'b0011 << {addr[1],1'b0}
  - 10 (word): 4'b1111
- Store data replication:
  - SB: byte replicated ×4.
  - SH: halfword ×2.
  - SW: passed through.
- Loads select a lane by the captured addr[1:0]:
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) is passed through.
- Fault conditions:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - funct3 in {011,110,111}.
  - Loads with funct3 1xx are legal; stores with funct3 1xx are illegal.
  - A faulted access makes no bus request and drives load_data_o to 0.
- load_data_o holds its value until the next retiring load or fault.
- Reset mid-transaction: return to IDLE immediately. A late rvalid after reset arrives in IDLE and is ignored.
- The bus guarantees at most one outstanding transaction and rvalid no earlier than the cycle after gnt.

Test Plan:
- LB from addr 0x103, rdata 0x80_00_00_00, gnt immediate, rvalid next cycle → be 4'b1000, load_data_o=0xFFFFFF80, done_o at T+3, stall_o high T..T+2.
- SH to addr 0x202, store_data 0x0000BEEF → dbus_we_o=1, dbus_addr_o=0x200, be=4'b1100, wdata=0xBEEFBEEF; done_o after rvalid; load_data_o unchanged.
- LW at addr 0x006 → no dbus_req_o; done_o and misaligned_o at T+1; load_data_o=0.
- LHU from addr 0x002, rdata 0xABCD1234, gnt withheld 3 cycles → dbus_req_o and fields stable all 3 cycles; load_data_o=0x0000ABCD.
- Reset asserted in WAIT, then rvalid pulsed after release → state IDLE, no done_o, all outputs 0.
- Back-to-back LW 0x10 then SW 0x14 with req_valid_i held through DONE → exactly two bus transactions and two done_o pulses; the first instruction is not re-accepted in its DONE cycle.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit_if
// Description : Data-bus bundle between the MEM-stage load/store engine and
//               the data memory. One outstanding transaction at a time:
//               a request is held until gnt, and rvalid (loads and stores)
//               completes it no earlier than the cycle after gnt.
// Signals     : req    - bus request (master -> slave)
//               we     - 1 = write (master -> slave)
//               addr   - word-aligned byte address (master -> slave)
//               be     - byte enables (master -> slave)
//               wdata  - lane-replicated store data (master -> slave)
//               gnt    - request accepted (slave -> master)
//               rvalid - response valid (slave -> master)
//               rdata  - read data (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit
// Description : MEM-stage load/store engine. Converts one EX->MEM access into
//               a single req/gnt + rvalid bus transaction, handling byte-lane
//               enables, store replication, load extension and fault
//               detection. stall_o freezes the upstream pipeline until the
//               access retires with a one-cycle done_o pulse.
// Ports       : clk, rst_n          - clock, async active-low reset
//               req_valid_i         - EX->MEM holds a valid instruction
//               mem_read_i/_write_i - access type (write wins if both)
//               funct3_i            - size / extension select
//               addr_i              - byte address from the ALU
//               store_data_i        - forwarded rs2 data
//               stall_o             - freeze upstream pipeline
//               done_o              - retire pulse
//               load_data_o         - extended load result (held)
//               misaligned_o        - fault flag, qualified by done_o
//               dbus                - data bus (master side)
// Parameters  : DATA_WIDTH - data/address width, only 32 is supported
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  misaligned_o,
  dmem_access_unit_if.master    dbus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  req_q;
  logic                  done_q;
  logic                  misaligned_q;
  logic [DATA_WIDTH-1:0] load_data_q;

  logic                  access_d;
  logic                  we_d;
  logic                  fault_d;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [7:0]            lane_byte_d;
  logic [15:0]           lane_half_d;
  logic [DATA_WIDTH-1:0] load_ext_d;

  assign access_d = req_valid_i & (mem_read_i | mem_write_i);
  assign we_d     = mem_write_i;

  // Decode of the incoming access: fault, byte enables, replicated data.
  always_comb begin
    fault_d = 1'b0;
    be_d    = 4'b1111;
    wdata_d = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{store_data_i[15:0]}};
        fault_d = addr_i[0];
      end
      2'b10: begin
        fault_d = (addr_i[1:0] != 2'b00);
      end
      default: begin
        fault_d = 1'b1;
      end
    endcase
    // 110 has no load meaning, and no store uses the unsigned encodings.
    if (funct3_i == 3'b110 || (we_d && funct3_i[2])) begin
      fault_d = 1'b1;
    end
  end

  // Lane select and extension of the returned word, using captured fields.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_byte_d = dbus.rdata[7:0];
      2'b01:   lane_byte_d = dbus.rdata[15:8];
      2'b10:   lane_byte_d = dbus.rdata[23:16];
      default: lane_byte_d = dbus.rdata[31:24];
    endcase
    lane_half_d = addr_q[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext_d = {{(DATA_WIDTH-8){lane_byte_d[7]}}, lane_byte_d};
      3'b001:  load_ext_d = {{(DATA_WIDTH-16){lane_half_d[15]}}, lane_half_d};
      3'b100:  load_ext_d = {{(DATA_WIDTH-8){1'b0}}, lane_byte_d};
      3'b101:  load_ext_d = {{(DATA_WIDTH-16){1'b0}}, lane_half_d};
      default: load_ext_d = dbus.rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      funct3_q     <= 3'b000;
      we_q         <= 1'b0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access_d) begin
            addr_q   <= addr_i;
            funct3_q <= funct3_i;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            if (fault_d) begin
              // Faults retire next cycle without touching the bus.
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
              load_data_q  <= '0;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (dbus.gnt) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (dbus.rvalid) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (!we_q) begin
              load_data_q <= load_ext_d;
            end
          end
        end
        default: begin
          // DONE ignores req_valid_i so the retiring instruction, still
          // sitting in EX->MEM this cycle, is never accepted twice.
          state_q      <= S_IDLE;
          done_q       <= 1'b0;
          misaligned_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_IDLE:  stall_o = access_d;
      S_DONE:  stall_o = 1'b0;
      default: stall_o = 1'b1;
    endcase
  end

  assign done_o       = done_q;
  assign misaligned_o = misaligned_q;
  assign load_data_o  = load_data_q;
  assign dbus.req     = req_q;
  assign dbus.we      = we_q;
  assign dbus.addr    = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign dbus.be      = be_q;
  assign dbus.wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Directed self-checking bench for dmem_access_unit. The bench
//               plays the data bus by hand, cycle by cycle, with expected
//               values worked out from the access encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic        misaligned_o;

  int n_tests;
  int n_fail;
  int txn_cnt;
  int done_cnt;

  dmem_access_unit_if #(.DATA_WIDTH(32)) dbus ();

  dmem_access_unit #(.DATA_WIDTH(32)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .load_data_o  (load_data_o),
    .misaligned_o (misaligned_o),
    .dbus         (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted bus transactions and retire pulses, observed at the clock edge.
  initial begin
    txn_cnt  = 0;
    done_cnt = 0;
  end
  always @(posedge clk) begin
    if (dbus.req && dbus.gnt) txn_cnt <= txn_cnt + 1;
    if (done_o)               done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    req_valid_i  = 1'b1;
    mem_read_i   = rd;
    mem_write_i  = wr;
    funct3_i     = f3;
    addr_i       = a;
    store_data_i = sd;
  endtask

  // Legal access with gnt withheld for gnt_wait cycles and rvalid right after gnt.
  task automatic bus_access(input string nm, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input int gnt_wait,
                            input logic [31:0] rdata, input logic exp_we,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    drive(rd, wr, f3, a, sd);
    #1;
    check({nm, " stall_at_accept"}, 32'(stall_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i <= gnt_wait; i++) begin
      check({nm, " req"},   32'(dbus.req), 32'd1);
      check({nm, " we"},    32'(dbus.we), 32'(exp_we));
      check({nm, " addr"},  dbus.addr, exp_addr);
      check({nm, " be"},    32'(dbus.be), 32'(exp_be));
      check({nm, " wdata"}, dbus.wdata, exp_wdata);
      check({nm, " stall_req"}, 32'(stall_o), 32'd1);
      if (i == gnt_wait) dbus.gnt = 1'b1;
      tick();
    end
    dbus.gnt = 1'b0;
    check({nm, " req_dropped"}, 32'(dbus.req), 32'd0);
    check({nm, " stall_wait"},  32'(stall_o), 32'd1);
    check({nm, " no_early_done"}, 32'(done_o), 32'd0);
    dbus.rvalid = 1'b1;
    dbus.rdata  = rdata;
    tick();
    dbus.rvalid = 1'b0;
    dbus.rdata  = 32'h0;
    check({nm, " done"},      32'(done_o), 32'd1);
    check({nm, " stall_done"}, 32'(stall_o), 32'd0);
    check({nm, " misaligned"}, 32'(misaligned_o), 32'd0);
    check({nm, " load_data"}, load_data_o, exp_ld);
    tick();
    check({nm, " done_clear"}, 32'(done_o), 32'd0);
  endtask

  task automatic fault_access(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a);
    drive(rd, wr, f3, a, 32'hDEADBEEF);
    #1;
    check({nm, " stall_at_accept"}, 32'(stall_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    check({nm, " done"},       32'(done_o), 32'd1);
    check({nm, " misaligned"}, 32'(misaligned_o), 32'd1);
    check({nm, " no_req"},     32'(dbus.req), 32'd0);
    check({nm, " load_zero"},  load_data_o, 32'h0);
    tick();
    check({nm, " done_clear"}, 32'(done_o), 32'd0);
    check({nm, " no_req_after"}, 32'(dbus.req), 32'd0);
  endtask

  int base_txn;
  int base_done;

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    funct3_i     = 3'b000;
    addr_i       = 32'h0;
    store_data_i = 32'h0;
    dbus.gnt     = 1'b0;
    dbus.rvalid  = 1'b0;
    dbus.rdata   = 32'h0;

    tick();
    tick();
    check("reset stall",  32'(stall_o), 32'd0);
    check("reset done",   32'(done_o), 32'd0);
    check("reset ld",     load_data_o, 32'h0);
    check("reset mis",    32'(misaligned_o), 32'd0);
    check("reset req",    32'(dbus.req), 32'd0);
    check("reset addr",   dbus.addr, 32'h0);
    check("reset be",     32'(dbus.be), 32'h0);
    check("reset wdata",  dbus.wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    //          name   rd    wr    f3      addr          sdata         gw rdata        we    exp_addr      be       wdata         load
    bus_access("LB",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h8000_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80);
    bus_access("SH",   1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 0, 32'h1234_5678, 1'b1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80);
    fault_access("LWmis", 1'b1, 1'b0, 3'b010, 32'h0000_0006);
    bus_access("LHU",  1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,        3, 32'hABCD_1234, 1'b0, 32'h0000_0000, 4'b1100, 32'h0,        32'h0000_ABCD);
    bus_access("LBpos",1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        1, 32'h0000_7F00, 1'b0, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_007F);
    bus_access("LHneg",1'b1, 1'b0, 3'b001, 32'h0000_0040, 32'h0,        0, 32'h1234_8001, 1'b0, 32'h0000_0040, 4'b0011, 32'h0,        32'hFFFF_8001);
    bus_access("LBU",  1'b1, 1'b0, 3'b100, 32'h0000_0042, 32'h0,        0, 32'h00F0_0000, 1'b0, 32'h0000_0040, 4'b0100, 32'h0,        32'h0000_00F0);
    bus_access("SBrw", 1'b1, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 0, 32'h0,        1'b1, 32'h0000_0000, 4'b1000, 32'hA5A5_A5A5, 32'h0000_00F0);
    fault_access("SBU",  1'b0, 1'b1, 3'b100, 32'h0000_0000);
    fault_access("LHmis",1'b1, 1'b0, 3'b001, 32'h0000_0001);
    fault_access("F011", 1'b1, 1'b0, 3'b011, 32'h0000_0000);
    fault_access("F110", 1'b1, 1'b0, 3'b110, 32'h0000_0000);

    // Back-to-back LW then SW with req_valid_i held through DONE.
    base_txn  = txn_cnt;
    base_done = done_cnt;
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    tick();
    check("b2b lw addr", dbus.addr, 32'h0000_0010);
    dbus.gnt = 1'b1;
    tick();
    dbus.gnt    = 1'b0;
    dbus.rvalid = 1'b1;
    dbus.rdata  = 32'h1122_3344;
    tick();
    dbus.rvalid = 1'b0;
    check("b2b lw done", 32'(done_o), 32'd1);
    check("b2b lw ld",   load_data_o, 32'h1122_3344);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'hCAFE_F00D);
    #1;
    check("b2b no_reaccept", 32'(dbus.req), 32'd0);
    check("b2b sw stall",    32'(stall_o), 32'd1);
    tick();
    check("b2b sw req",   32'(dbus.req), 32'd1);
    check("b2b sw we",    32'(dbus.we), 32'd1);
    check("b2b sw addr",  dbus.addr, 32'h0000_0014);
    check("b2b sw wdata", dbus.wdata, 32'hCAFE_F00D);
    dbus.gnt = 1'b1;
    tick();
    dbus.gnt    = 1'b0;
    dbus.rvalid = 1'b1;
    tick();
    dbus.rvalid = 1'b0;
    req_valid_i = 1'b0;
    check("b2b sw done", 32'(done_o), 32'd1);
    check("b2b sw ld_kept", load_data_o, 32'h1122_3344);
    tick();
    tick();
    check("b2b txns",  32'(txn_cnt - base_txn), 32'd2);
    check("b2b dones", 32'(done_cnt - base_done), 32'd2);

    // Reset while waiting for rvalid; a late rvalid must be ignored.
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0);
    tick();
    req_valid_i = 1'b0;
    dbus.gnt = 1'b1;
    tick();
    dbus.gnt = 1'b0;
    check("rst wait stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst async req",   32'(dbus.req), 32'd0);
    check("rst async stall", 32'(stall_o), 32'd0);
    tick();
    rst_n = 1'b1;
    dbus.rvalid = 1'b1;
    dbus.rdata  = 32'hFFFF_FFFF;
    tick();
    dbus.rvalid = 1'b0;
    check("rst late done",  32'(done_o), 32'd0);
    check("rst late ld",    load_data_o, 32'h0);
    check("rst late stall", 32'(stall_o), 32'd0);
    check("rst late addr",  dbus.addr, 32'h0);
    check("rst late be",    32'(dbus.be), 32'h0);
    check("rst late wdata", dbus.wdata, 32'h0);
    check("rst late req",   32'(dbus.req), 32'd0);
    tick();
    check("rst late done2", 32'(done_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
